lcd_hd44780_driver: RTL

//  Downstream display stage of the sqrt calculator: owns the 16x2 HD44780 LCD bus.

---
 rtl/lcd_pkg.sv | 39 +++
 rtl/lcd_byte_writer.sv | 123 ++++++++++++
 rtl/lcd_hd44780_driver.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : lcd_pkg                                                       |
// | Description: HD44780 command bytes, FSM state encodings and a counter      |
// |              width helper shared by the LCD driver and its byte writer.    |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package lcd_pkg;

  localparam logic [7:0] CMD_FUNC_8B2L = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;  // display on, cursor off
  localparam logic [7:0] CMD_CLEAR     = 8'h01;  // clear display (slow command)
  localparam logic [7:0] CMD_ENTRY_INC = 8'h06;  // auto-increment, no shift
  localparam logic [7:0] CMD_LINE0     = 8'h80;  // DDRAM address 0x00
  localparam logic [7:0] CMD_LINE1     = 8'hC0;  // DDRAM address 0x40

  // Top-level sequencer states
  typedef enum logic [1:0] {
    PWRUP = 2'd0,
    INIT  = 2'd1,
    IDLE  = 2'd2,
    FRAME = 2'd3
  } lcd_state_t;

  // Byte writer phases
  typedef enum logic [1:0] {
    WR_IDLE  = 2'd0,
    WR_SETUP = 2'd1,
    WR_EHI   = 2'd2,
    WR_WAIT  = 2'd3
  } wr_phase_t;

  // Bits needed for a down-counter loaded with (n - 1); never narrower than 1.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_byte_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : lcd_byte_writer                                               |
// | Description: Writes one byte to the HD44780 bus: SETUP (E low, bus driven),|
// |              E high, then a fixed post-wait (long for the clear command).  |
// |              A start accepted while o_done is high chains the next byte    |
// |              with no idle cycle in between.                                |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk_i    in   1  system clock                                            |
// |   rst      in   1  asynchronous active-high reset                          |
// |   i_start  in   1  begin a byte (honoured in WR_IDLE or on the done cycle) |
// |   i_rs     in   1  register select for the byte                            |
// |   i_data   in   8  byte value                                              |
// |   i_long   in   1  use the long post-wait                                  |
// |   o_done   out  1  high during the last post-wait cycle                    |
// |   o_e      out  1  lcd_e strobe                                            |
// |   o_rs     out  1  lcd_rs                                                  |
// |   o_data   out  8  DB7..DB0                                                |
// +----------------------------------------------------------------------------+
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC = 2,
  parameter int E_CYC     = 12,
  parameter int CMD_CYC   = 2_000,
  parameter int CLR_CYC   = 82_000
) (
  input  logic       clk_i,
  input  logic       rst,
  input  logic       i_start,
  input  logic       i_rs,
  input  logic [7:0] i_data,
  input  logic       i_long,
  output logic       o_done,
  output logic       o_e,
  output logic       o_rs,
  output logic [7:0] o_data
);

  localparam int C_MAX_AB = (SETUP_CYC > E_CYC) ? SETUP_CYC : E_CYC;
  localparam int C_MAX_CD = (CMD_CYC > CLR_CYC) ? CMD_CYC : CLR_CYC;
  localparam int C_MAX    = (C_MAX_AB > C_MAX_CD) ? C_MAX_AB : C_MAX_CD;
  localparam int CW       = cnt_width(C_MAX);

  localparam logic [CW-1:0] C_SETUP_LOAD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] C_E_LOAD     = CW'(E_CYC - 1);
  localparam logic [CW-1:0] C_CMD_LOAD   = CW'(CMD_CYC - 1);
  localparam logic [CW-1:0] C_CLR_LOAD   = CW'(CLR_CYC - 1);

  wr_phase_t     r_phase;
  logic [CW-1:0] r_cnt;
  logic          r_long;
  logic          r_e;
  logic          r_rs;
  logic [7:0]    r_data;

  assign o_done = (r_phase == WR_WAIT) && (r_cnt == '0);
  assign o_e    = r_e;
  assign o_rs   = r_rs;
  assign o_data = r_data;

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      r_phase <= WR_IDLE;
      r_cnt   <= '0;
      r_long  <= 1'b0;
      r_e     <= 1'b0;
      r_rs    <= 1'b0;
      r_data  <= 8'h00;
    end else begin
      case (r_phase)
        WR_IDLE: begin
          if (i_start) begin
            r_phase <= WR_SETUP;
            r_cnt   <= C_SETUP_LOAD;
            r_rs    <= i_rs;
            r_data  <= i_data;
            r_long  <= i_long;
          end
        end
        WR_SETUP: begin
          if (r_cnt == '0) begin
            r_phase <= WR_EHI;
            r_cnt   <= C_E_LOAD;
            r_e     <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        WR_EHI: begin
          if (r_cnt == '0) begin
            r_phase <= WR_WAIT;
            r_cnt   <= r_long ? C_CLR_LOAD : C_CMD_LOAD;
            r_e     <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        WR_WAIT: begin
          if (r_cnt == '0) begin
            // Chain straight into the next byte's setup when one is offered.
            if (i_start) begin
              r_phase <= WR_SETUP;
              r_cnt   <= C_SETUP_LOAD;
              r_rs    <= i_rs;
              r_data  <= i_data;
              r_long  <= i_long;
            end else begin
              r_phase <= WR_IDLE;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_phase <= WR_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/lcd_hd44780_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : lcd_hd44780_driver                                            |
// | Description: Write-only 16x2 HD44780 driver. Waits out panel power-up,     |
// |              sends the init commands, then redraws both lines from a       |
// |              snapshot on each update request. Requests arriving while busy |
// |              collapse into one pending redraw.                             |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   clk_i     in   1    system clock                                         |
// |   rst       in   1    asynchronous active-high reset                       |
// |   line0_i   in   128  line 0 text, char 0 in [127:120]                     |
// |   line1_i   in   128  line 1 text, same packing                            |
// |   update_i  in   1    one-cycle redraw request                             |
// |   busy_o    out  1    high during power-up, init and frame writes          |
// |   lcd_e     out  1    enable strobe                                        |
// |   lcd_rs    out  1    0 = command, 1 = character                           |
// |   lcd_rw    out  1    tied 0                                               |
// |   lcd_on    out  1    tied 1                                               |
// |   lcd_blon  out  1    tied 1                                               |
// |   data_lcd  out  8    DB7..DB0                                             |
// +----------------------------------------------------------------------------+
module lcd_hd44780_driver
  import lcd_pkg::*;
#(
  parameter int PWRUP_CYC = 750_000,
  parameter int SETUP_CYC = 2,
  parameter int E_CYC     = 12,
  parameter int CMD_CYC   = 2_000,
  parameter int CLR_CYC   = 82_000
) (
  input  logic         clk_i,
  input  logic         rst,
  input  logic [127:0] line0_i,
  input  logic [127:0] line1_i,
  input  logic         update_i,
  output logic         busy_o,
  output logic         lcd_e,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic         lcd_on,
  output logic         lcd_blon,
  output logic [7:0]   data_lcd
);

  localparam int              PW           = cnt_width(PWRUP_CYC);
  localparam logic [PW-1:0]   C_PWRUP_LOAD = PW'(PWRUP_CYC - 1);
  localparam logic [5:0]      C_INIT_LAST  = 6'd3;
  localparam logic [5:0]      C_FRAME_LAST = 6'd33;

  lcd_state_t    r_state;
  logic [PW-1:0] r_cnt;
  logic [5:0]    r_idx;
  logic          r_pending;
  logic [255:0]  r_buf;
  logic          r_busy;

  logic          w_start;
  logic          w_frame;
  logic [5:0]    w_idx;
  logic [4:0]    w_chr;
  logic          w_rs;
  logic [7:0]    w_data;
  logic          w_long;
  logic          w_done;

  // Decide whether a byte starts on this edge and which byte index it is.
  always_comb begin
    w_start = 1'b0;
    w_frame = (r_state == FRAME);
    w_idx   = r_idx + 6'd1;
    case (r_state)
      PWRUP: begin
        w_start = (r_cnt == '0);
        w_idx   = '0;
      end
      INIT:  w_start = w_done && (r_idx != C_INIT_LAST);
      IDLE: begin
        // Frame byte 0 is the line-0 address, so the snapshot is not needed yet.
        w_start = update_i || r_pending;
        w_idx   = '0;
        w_frame = 1'b1;
      end
      FRAME: w_start = w_done && (r_idx != C_FRAME_LAST);
      default: w_start = 1'b0;
    endcase
  end

  // Byte lookup: frame index 1..16 -> chars 0..15, 18..33 -> chars 16..31.
  always_comb begin
    w_rs   = 1'b0;
    w_data = CMD_FUNC_8B2L;
    w_chr  = (w_idx <= 6'd16) ? 5'(w_idx - 6'd1) : 5'(w_idx - 6'd2);
    if (!w_frame) begin
      case (w_idx[1:0])
        2'd0:    w_data = CMD_FUNC_8B2L;
        2'd1:    w_data = CMD_DISP_ON;
        2'd2:    w_data = CMD_CLEAR;
        default: w_data = CMD_ENTRY_INC;
      endcase
    end else if (w_idx == 6'd0) begin
      w_data = CMD_LINE0;
    end else if (w_idx == 6'd17) begin
      w_data = CMD_LINE1;
    end else begin
      w_rs   = 1'b1;
      w_data = r_buf[8*(31 - int'(w_chr)) +: 8];
    end
  end

  // Only the clear command needs the long settle time.
  assign w_long = !w_rs && (w_data == CMD_CLEAR);

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      r_state   <= PWRUP;
      r_cnt     <= C_PWRUP_LOAD;
      r_idx     <= '0;
      r_pending <= 1'b0;
      r_buf     <= '0;
      r_busy    <= 1'b1;
    end else begin
      if (update_i && (r_state != IDLE)) begin
        r_pending <= 1'b1;
      end
      case (r_state)
        PWRUP: begin
          if (r_cnt == '0) begin
            r_state <= INIT;
            r_idx   <= '0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        INIT: begin
          if (w_done) begin
            if (r_idx == C_INIT_LAST) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_idx <= r_idx + 6'd1;
            end
          end
        end
        IDLE: begin
          if (update_i || r_pending) begin
            r_state   <= FRAME;
            r_busy    <= 1'b1;
            r_pending <= 1'b0;
            r_idx     <= '0;
            r_buf     <= {line0_i, line1_i};
          end
        end
        FRAME: begin
          if (w_done) begin
            if (r_idx == C_FRAME_LAST) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_idx <= r_idx + 6'd1;
            end
          end
        end
        default: r_state <= PWRUP;
      endcase
    end
  end

  lcd_byte_writer #(
    .SETUP_CYC (SETUP_CYC),
    .E_CYC     (E_CYC),
    .CMD_CYC   (CMD_CYC),
    .CLR_CYC   (CLR_CYC)
  ) u_writer (
    .clk_i   (clk_i),
    .rst     (rst),
    .i_start (w_start),
    .i_rs    (w_rs),
    .i_data  (w_data),
    .i_long  (w_long),
    .o_done  (w_done),
    .o_e     (lcd_e),
    .o_rs    (lcd_rs),
    .o_data  (data_lcd)
  );

  assign busy_o   = r_busy;
  assign lcd_rw   = 1'b0;
  assign lcd_on   = 1'b1;
  assign lcd_blon = 1'b1;

endmodule
`default_nettype wire
